ibex_rf_access_ctrl: RTL

Access controller in front of the flip-flop register file's single write port and read port B. After reset it sequences a clear of every architectural register. It then shares the write port and read port B between the core and a debug requester: core has priority, and a wait counter stops debug starvation by stalling the core for one cycle. Read port A is core-only and bypasses this block.

---
 rtl/ibex_rf_access_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ibex_rf_access_ctrl.sv
// Register-file write/read-B access controller: post-reset clear sweep,
// then core-priority sharing with a starvation-bounded debug requester.
module ibex_rf_access_ctrl #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter bit                   InitEnable  = 1'b1,
  parameter int unsigned          MaxWait     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 core_we_i,
  input  logic [4:0]           core_waddr_i,
  input  logic [DataWidth-1:0] core_wdata_i,
  input  logic                 core_rb_req_i,
  input  logic [4:0]           core_raddr_b_i,
  output logic                 core_stall_o,
  output logic                 init_done_o,

  input  logic                 dbg_req_i,
  input  logic                 dbg_we_i,
  input  logic [4:0]           dbg_addr_i,
  input  logic [DataWidth-1:0] dbg_wdata_i,
  output logic                 dbg_gnt_o,
  output logic                 dbg_rvalid_o,
  output logic [DataWidth-1:0] dbg_rdata_o,
  output logic                 dbg_err_o,

  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic [4:0]           rf_raddr_b_o,
  input  logic [DataWidth-1:0] rf_rdata_b_i
);

  localparam int unsigned AddrWidth = RV32E ? 4 : 5;
  localparam int unsigned NumWords  = 2 ** AddrWidth;
  localparam logic [4:0]  LastCnt   = 5'(NumWords - 2);
  localparam logic [7:0]  WaitLim   = 8'(MaxWait - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e               state_q;
  logic [4:0]           cnt_q;
  logic [7:0]           wait_q, wait_d;
  logic                 force_q, force_d;
  logic                 init_done_q;
  logic                 rvalid_q;
  logic                 err_q;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic in_run;
  logic core_act;
  logic dbg_oor;
  logic dbg_gnt;

  assign in_run   = (state_q == RUN);
  assign core_act = core_we_i | core_rb_req_i;
  assign dbg_oor  = RV32E && dbg_addr_i[4];
  assign dbg_gnt  = in_run & dbg_req_i & (force_q | ~core_act);

  assign core_stall_o = ~in_run | force_q;
  assign init_done_o  = init_done_q;
  assign dbg_gnt_o    = dbg_gnt;
  assign dbg_rvalid_o = rvalid_q;
  assign dbg_err_o    = err_q;
  assign dbg_rdata_o  = rdata_q;

  // cnt_q counts from 0 so the sweep address is cnt_q+1
  always_comb begin
    rf_we_o      = 1'b0;
    rf_waddr_o   = core_waddr_i;
    rf_wdata_o   = core_wdata_i;
    rf_raddr_b_o = core_raddr_b_i;
    unique case (1'b1)
      !in_run: begin
        rf_we_o    = 1'b1;
        rf_waddr_o = cnt_q + 5'd1;
        rf_wdata_o = WordZeroVal;
      end
      dbg_gnt: begin
        rf_raddr_b_o = dbg_addr_i;
        if (dbg_we_i && !dbg_oor) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = dbg_addr_i;
          rf_wdata_o = dbg_wdata_i;
        end
      end
      default: begin
        rf_we_o = core_we_i & ~force_q;
      end
    endcase
  end

  always_comb begin
    wait_d = '0;
    if (in_run && dbg_req_i && !dbg_gnt && wait_q != 8'hFF) begin
      wait_d = wait_q + 8'd1;
    end
  end

  assign force_d = in_run & dbg_req_i & ~dbg_gnt & (wait_q == WaitLim);

  always_comb begin
    rdata_d = '0;
    if (dbg_gnt && !dbg_we_i && !dbg_oor) begin
      rdata_d = (dbg_addr_i == 5'd0) ? WordZeroVal : rf_rdata_b_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= InitEnable ? INIT : RUN;
      init_done_q <= !InitEnable;
      cnt_q       <= '0;
      wait_q      <= '0;
      force_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          if (cnt_q == LastCnt) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        RUN: begin
          state_q     <= RUN;
          init_done_q <= 1'b1;
        end
        default: state_q <= INIT;
      endcase
      wait_q   <= wait_d;
      force_q  <= force_d;
      rvalid_q <= dbg_gnt;
      err_q    <= dbg_gnt & dbg_oor;
      rdata_q  <= rdata_d;
    end
  end

endmodule
